// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and frame-format constants for the IMEM boot loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_LEN_LO = 3'd3,
        ST_DATA   = 3'd4,
        ST_CHK    = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_HDR_BYTES   = 3;
    localparam int         BYTES_PER_WORD    = 4;

    // Largest legal word count for a given word-address width
    function automatic logic [16:0] max_words(input int addr_width);
        return 17'(1) << addr_width;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and IMEM write port out of the loader
interface imem_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    // Host side: supplies the byte stream and observes IMEM writes
    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side
    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs four big-endian bytes into a 32-bit word
module imem_loader_byte_assembler (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_strobe_o
);

    logic [1:0]  idx_q;
    logic [23:0] shift_q;

    // Shift in accepted bytes; the 4th byte completes the word combinationally
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid_i) begin
            idx_q   <= idx_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_i};
        end
    end

    assign word_o        = {shift_q, byte_i};
    assign word_strobe_o = byte_valid_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to IMEM writer that holds the core in reset until loaded
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_nrst_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [15:0]  word_count_o
);

    localparam logic [16:0] MAX_WORDS    = max_words(ADDR_WIDTH);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [7:0]  checksum_q;
    logic [31:0] timer_q;
    logic [15:0] word_count_q;
    logic        imem_we_q;
    logic [31:0] imem_wdata_q;

    logic        rx_fire;
    logic        data_fire;
    logic        timed;
    logic        timeout_hit;
    logic        last_word;
    logic [16:0] len_n;
    logic [31:0] asm_word;
    logic        asm_strobe;

    assign rx_fire     = bus.rx_valid && bus.rx_ready;
    assign data_fire   = rx_fire && (state_q == ST_DATA) && !start_i;
    assign timed       = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                         (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign timeout_hit = timed && !rx_fire && (timer_q == TIMEOUT_LAST);
    assign len_n       = {1'b0, len_hi_q, bus.rx_data};
    // Previous word's write has always landed before the next 4th byte arrives
    assign last_word   = ({1'b0, word_count_q} + 17'd1) == {1'b0, len_q};

    imem_loader_byte_assembler u_asm (
        .clk_i         (clk_i),
        .clear_i       (rst_i || start_i),
        .byte_valid_i  (data_fire),
        .byte_i        (bus.rx_data),
        .word_o        (asm_word),
        .word_strobe_o (asm_strobe)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start overrides any byte accepted in the same cycle
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:   if (rx_fire && bus.rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
                ST_LEN_HI: if (rx_fire) state_d = ST_LEN_LO;
                           else if (timeout_hit) state_d = ST_ERR;
                ST_LEN_LO: begin
                    if (rx_fire) begin
                        if (len_n == 17'd0)          state_d = ST_CHK;
                        else if (len_n > MAX_WORDS)  state_d = ST_ERR;
                        else                         state_d = ST_DATA;
                    end else if (timeout_hit) begin
                        state_d = ST_ERR;
                    end
                end
                ST_DATA:   if (asm_strobe && last_word) state_d = ST_CHK;
                           else if (timeout_hit) state_d = ST_ERR;
                ST_CHK: begin
                    if (rx_fire) state_d = (bus.rx_data == checksum_q) ? ST_DONE : ST_ERR;
                    else if (timeout_hit) state_d = ST_ERR;
                end
                default:   state_d = state_q;
            endcase
        end
    end

    // Status and handshake outputs are pure functions of the state
    always_comb begin
        bus.rx_ready = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        error_o      = 1'b0;
        cpu_nrst_o   = 1'b0;
        case (state_q)
            ST_SYNC, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK: begin
                bus.rx_ready = 1'b1;
                busy_o       = 1'b1;
            end
            ST_DONE: begin
                done_o     = 1'b1;
                cpu_nrst_o = 1'b1;
            end
            ST_ERR:  error_o = 1'b1;
            default: ;
        endcase
    end

    // Length capture, checksum, idle timer, word counter and registered IMEM write
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_hi_q     <= 8'd0;
            len_q        <= 16'd0;
            checksum_q   <= 8'd0;
            timer_q      <= 32'd0;
            word_count_q <= 16'd0;
            imem_we_q    <= 1'b0;
            imem_wdata_q <= 32'd0;
        end else begin
            imem_we_q <= asm_strobe;
            if (asm_strobe) imem_wdata_q <= asm_word;

            if (start_i || !timed || rx_fire) timer_q <= 32'd0;
            else                              timer_q <= timer_q + 32'd1;

            if (start_i) begin
                len_hi_q     <= 8'd0;
                len_q        <= 16'd0;
                checksum_q   <= 8'd0;
                word_count_q <= 16'd0;
            end else begin
                if (imem_we_q) word_count_q <= word_count_q + 16'd1;
                if (data_fire) checksum_q <= checksum_q ^ bus.rx_data;
                if (rx_fire && state_q == ST_LEN_HI) len_hi_q <= bus.rx_data;
                if (rx_fire && state_q == ST_LEN_LO) len_q <= len_n[15:0];
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.imem_addr  = BASE_ADDR + {14'd0, word_count_q, 2'b00};
    assign word_count_o   = word_count_q;

endmodule
